// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM states, parity modes,
// frame constants and the parity helper.
package uart_tx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    // Parity bit for a byte: even parity is the XOR of the data bits, odd is its complement.
    function automatic logic parity_bit(logic [DATA_BITS-1:0] data, parity_e mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter's holding register.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_rdy;

    modport master (output tx_data, output tx_valid, input  tx_rdy);
    modport slave  (input  tx_data, input  tx_valid, output tx_rdy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2
// stop bits. Bit timing comes from the external bd_rate strobe. A one-byte
// holding register lets the next frame start straight after the last stop bit.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      bd_rate,
    uart_tx_if.slave  tx_if,
    output logic      tx,
    output logic      tx_busy,
    output logic      tx_done
);

    generate
        if (!(PARITY == "NONE" || PARITY == "EVEN" || PARITY == "ODD")) begin : g_bad_parity
            $error("uart_tx: PARITY must be \"NONE\", \"EVEN\" or \"ODD\"");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam parity_e P_MODE      = (PARITY == "EVEN") ? PAR_EVEN :
                                      (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
    localparam logic    P_LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e            r_state,    w_state;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shift,    w_shift;
    logic [2:0]           r_bit_cnt,  w_bit_cnt;
    logic                 r_stop_cnt, w_stop_cnt;
    logic                 r_par,      w_par;
    logic                 r_rdy,      w_rdy;
    logic                 r_tx,       w_tx;
    logic                 r_busy,     w_busy;
    logic                 r_done,     w_done;
    logic                 w_accept;
    logic                 w_load;

    assign w_accept     = tx_if.tx_valid & r_rdy;
    assign tx_if.tx_rdy = r_rdy;
    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done      = r_done;

    // Next-state, next-bit and holding-register bookkeeping; the FSM only moves on bd_rate.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
        w_state    = r_state;
        w_shift    = r_shift;
        w_bit_cnt  = r_bit_cnt;
        w_stop_cnt = r_stop_cnt;
        w_par      = r_par;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_load     = 1'b0;
        w_rdy      = r_rdy;

        if (bd_rate) begin
            unique case (r_state)
                ST_IDLE: begin
                    // A byte accepted on this same cycle is not yet in hold, so it waits for the next strobe.
                    if (!r_rdy) begin
                        w_load  = 1'b1;
                        w_tx    = 1'b0;
                        w_busy  = 1'b1;
                        w_state = ST_START;
                    end
                end
                ST_START: begin
                    w_tx      = r_shift[0];
                    w_bit_cnt = 3'd0;
                    w_state   = ST_DATA;
                end
                ST_DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_stop_cnt = 1'b0;
                        if (P_MODE == PAR_NONE) begin
                            w_tx    = 1'b1;
                            w_state = ST_STOP;
                        end else begin
                            w_tx    = r_par;
                            w_state = ST_PAR;
                        end
                    end else begin
                        w_shift   = r_shift >> 1;
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        w_tx      = r_shift[1];
                    end
                end
                ST_PAR: begin
                    w_tx       = 1'b1;
                    w_stop_cnt = 1'b0;
                    w_state    = ST_STOP;
                end
                ST_STOP: begin
                    if (r_stop_cnt == P_LAST_STOP) begin
                        w_done = 1'b1;
                        if (!r_rdy) begin
                            // Next byte already waiting: its start bit follows the stop bit directly.
                            w_load  = 1'b1;
                            w_tx    = 1'b0;
                            w_state = ST_START;
                        end else begin
                            w_tx    = 1'b1;
                            w_busy  = 1'b0;
                            w_state = ST_IDLE;
                        end
                    end else begin
                        w_stop_cnt = r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    w_tx    = 1'b1;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end
            endcase
        end

        // Moving hold into the shifter frees the holding register; accept and move never coincide.
        if (w_load) begin
            w_shift = r_hold;
            w_par   = parity_bit(r_hold, P_MODE);
        end

        if (w_accept) begin
            w_rdy = 1'b0;
        end else if (w_load) begin
            w_rdy = 1'b1;
        end
    end

    // State register plus datapath registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the hold data is cleared along with its full flag, so a reset leaves no stale byte behind.
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_rdy      <= 1'b1;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the pre-edge values.
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_bit_cnt  <= w_bit_cnt;
            r_stop_cnt <= w_stop_cnt;
            r_par      <= w_par;
            r_rdy      <= w_rdy;
            r_tx       <= w_tx;
            r_busy     <= w_busy;
            r_done     <= w_done;
            if (w_accept) begin
                r_hold <= tx_if.tx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Three instances cover the parity/stop-bit
// variants: 0 = NONE/1 stop, 1 = EVEN/2 stop, 2 = ODD/1 stop. A bench-side
// serial decoder turns each line back into bytes and flags framing/parity errors.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       bd_rate;
    logic [7:0] drv_data [3];
    logic [2:0] drv_valid;
    logic [2:0] rdy, txl, busy, done;

    uart_tx_if if0 ();
    uart_tx_if if1 ();
    uart_tx_if if2 ();

    assign if0.tx_data  = drv_data[0];
    assign if1.tx_data  = drv_data[1];
    assign if2.tx_data  = drv_data[2];
    assign if0.tx_valid = drv_valid[0];
    assign if1.tx_valid = drv_valid[1];
    assign if2.tx_valid = drv_valid[2];
    assign rdy[0]       = if0.tx_rdy;
    assign rdy[1]       = if1.tx_rdy;
    assign rdy[2]       = if2.tx_rdy;

    uart_tx #(.PARITY("NONE"), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bd_rate(bd_rate), .tx_if(if0),
        .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx #(.PARITY("EVEN"), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bd_rate(bd_rate), .tx_if(if1),
        .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx #(.PARITY("ODD"), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bd_rate(bd_rate), .tx_if(if2),
        .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud strobe: one clock high out of every four.
    initial begin
        bd_rate = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bd_rate = 1'b1;
            @(negedge clk);
            bd_rate = 1'b0;
        end
    end

    int         total, bad;
    int         cur_k;
    int         dst [3], dcnt [3], gap [3], last_gap [3], done_cnt [3], busy_fall [3];
    logic [7:0] dsh [3];
    logic       derr [3];
    logic [2:0] busy_q;
    logic       bd_at;
    logic [8:0] rxq [3][$];
    logic       log_q [$];

    typedef struct {
        int         k;
        logic [7:0] data;
        string      frame;
    } vec_t;

    vec_t vecs [7];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bench UART receiver working on one line sample per bit period.
    task automatic decode(int k, logic s);
        case (dst[k])
            0: begin
                if (s == 1'b0) begin
                    last_gap[k] = gap[k];
                    gap[k]      = 0;
                    dst[k]      = 1;
                    dcnt[k]     = 0;
                    derr[k]     = 1'b0;
                end else begin
                    gap[k]++;
                end
            end
            1: begin
                dsh[k] = {s, dsh[k][7:1]};
                dcnt[k]++;
                if (dcnt[k] == 8) begin
                    dcnt[k] = 0;
                    dst[k]  = (k == 0) ? 3 : 2;
                end
            end
            2: begin
                if (s !== ((k == 2) ? ~^dsh[k] : ^dsh[k])) derr[k] = 1'b1;
                dst[k] = 3;
            end
            default: begin
                if (s !== 1'b1) derr[k] = 1'b1;
                dcnt[k]++;
                if (dcnt[k] == ((k == 1) ? 2 : 1)) begin
                    rxq[k].push_back({derr[k], dsh[k]});
                    dst[k] = 0;
                end
            end
        endcase
    endtask

    // Line monitor: samples 1 ns after each edge; one bit sample per bd_rate edge.
    always @(posedge clk) begin
        bd_at = bd_rate;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) done_cnt[k]++;
            if (busy_q[k] && !busy[k]) busy_fall[k]++;
            busy_q[k] = busy[k];
            if (bd_at) begin
                if (k == cur_k) log_q.push_back(txl[k]);
                decode(k, txl[k]);
            end
        end
    end

    task automatic wait_bd(int n);
        repeat (n) begin
            @(posedge clk);
            while (!bd_rate) @(posedge clk);
        end
        #2;
    endtask

    task automatic send(int k, logic [7:0] d);
        int n = 0;
        @(negedge clk);
        drv_data[k]  = d;
        drv_valid[k] = 1'b1;
        while (!rdy[k] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("send%0d_rdy", k), rdy[k], 1);
        @(negedge clk);
        drv_valid[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int want, int lim, string name);
        int n = 0;
        while (done_cnt[k] < want && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(name, done_cnt[k], want);
    endtask

    task automatic wait_busy(int k, string name);
        int n = 0;
        while (!busy[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, busy[k], 1);
    endtask

    task automatic pop_check(int k, logic [7:0] d, string name);
        logic [8:0] r;
        r = (rxq[k].size() > 0) ? rxq[k].pop_front() : 9'h1xx;
        check(name, r, {1'b0, d});
    endtask

    task automatic reset_check(string tag);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s%0d_tx", tag, k),   txl[k],  1);
            check($sformatf("%s%0d_busy", tag, k), busy[k], 0);
            check($sformatf("%s%0d_rdy", tag, k),  rdy[k],  1);
            check($sformatf("%s%0d_done", tag, k), done[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dst[k] = 0;
            rxq[k].delete();
        end
        log_q.delete();
    endtask

    task automatic run_vec(int i);
        int          k, f, len, d0;
        logic [12:0] got, exp;
        k   = vecs[i].k;
        len = vecs[i].frame.len();
        @(negedge clk);
        cur_k = k;
        log_q.delete();
        d0 = done_cnt[k];
        send(k, vecs[i].data);
        wait_done(k, d0 + 1, 400, $sformatf("vec%0d_done", i));
        f = 0;
        while (f < log_q.size() && log_q[f] != 1'b0) f++;
        got = '0;
        exp = '0;
        for (int b = 0; b <= len; b++) begin
            exp[b] = (b == len) ? 1'b1 : (vecs[i].frame[b] == "1");
            got[b] = (f + b < log_q.size()) ? log_q[f + b] : 1'bx;
        end
        check($sformatf("vec%0d_frame", i), got, exp);
        pop_check(k, vecs[i].data, $sformatf("vec%0d_rx", i));
    endtask

    task automatic stream(int k);
        int n = 0;
        for (int b = 0; b < 256; b++) send(k, 8'(b));
        while (rxq[k].size() < 256 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("loop%0d_count", k), rxq[k].size(), 256);
        for (int b = 0; b < 256; b++) pop_check(k, 8'(b), $sformatf("loop%0d_byte%0d", k, b));
    endtask

    initial begin
        int d0, bf0, lat;
        total     = 0;
        bad       = 0;
        cur_k     = 0;
        rst_n     = 1'b0;
        drv_valid = '0;
        busy_q    = '0;
        for (int k = 0; k < 3; k++) begin
            drv_data[k]  = 8'h00;
            dst[k]       = 0;
            dcnt[k]      = 0;
            gap[k]       = 0;
            last_gap[k]  = -1;
            done_cnt[k]  = 0;
            busy_fall[k] = 0;
            dsh[k]       = 8'h00;
            derr[k]      = 1'b0;
        end

        reset_check("reset");

        // Expected line per bit period: start, data LSB first, parity, stop(s).
        vecs[0] = '{0, 8'hAD, "0101101011"};
        vecs[1] = '{1, 8'hAD, "010110101111"};
        vecs[2] = '{2, 8'hAD, "01011010101"};
        vecs[3] = '{0, 8'h3C, "0001111001"};
        vecs[4] = '{1, 8'h00, "000000000011"};
        vecs[5] = '{2, 8'hFF, "01111111111"};
        vecs[6] = '{1, 8'h01, "010000000111"};
        for (int i = 0; i < 7; i++) run_vec(i);

        // Accept drops tx_rdy; it returns when the byte leaves hold at the start bit.
        @(negedge clk);
        drv_data[0]  = 8'hC3;
        drv_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        check("accept_rdy_low", rdy[0], 0);
        @(negedge clk);
        drv_valid[0] = 1'b0;
        d0  = done_cnt[0];
        lat = 0;
        while (txl[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("start_latency_ok", lat <= 5, 1);
        check("rdy_after_start", rdy[0], 1);
        check("busy_at_start", busy[0], 1);
        wait_done(0, d0 + 1, 400, "c3_done");
        pop_check(0, 8'hC3, "c3_rx");

        // Load on the same cycle as a strobe: the start bit waits one more period.
        wait_bd(1);
        repeat (4) @(negedge clk);
        drv_data[0]  = 8'h96;
        drv_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        check("same_cycle_rdy", rdy[0], 0);
        check("same_cycle_tx_idle", txl[0], 1);
        check("same_cycle_not_busy", busy[0], 0);
        @(negedge clk);
        drv_valid[0] = 1'b0;
        wait_bd(1);
        check("same_cycle_start_next", txl[0], 0);
        check("same_cycle_busy_next", busy[0], 1);
        wait_done(0, d0 + 2, 400, "b96_done");
        pop_check(0, 8'h96, "b96_rx");

        // Back-to-back frames, then a write into a full holding register.
        d0  = done_cnt[0];
        bf0 = busy_fall[0];
        send(0, 8'h55);
        wait_busy(0, "b2b_busy");
        wait_bd(3);
        send(0, 8'h0F);
        @(negedge clk);
        drv_data[0]  = 8'hFF;
        drv_valid[0] = 1'b1;
        repeat (8) @(negedge clk);
        check("full_hold_rdy", rdy[0], 0);
        drv_valid[0] = 1'b0;
        wait_done(0, d0 + 2, 800, "b2b_done");
        check("b2b_no_gap", last_gap[0], 0);
        check("b2b_busy_held", busy_fall[0], bf0 + 1);
        pop_check(0, 8'h55, "b2b_rx0");
        pop_check(0, 8'h0F, "b2b_rx1");
        wait_bd(30);
        check("ff_not_sent", rxq[0].size(), 0);
        check("ff_no_extra_done", done_cnt[0], d0 + 2);

        // Reset during DATA aborts the frame; a later byte goes out cleanly.
        send(0, 8'hAD);
        wait_busy(0, "abort_busy");
        wait_bd(2);
        check("pre_reset_tx_low", txl[0], 0);
        reset_check("midreset");
        run_vec(3);

        // Loopback through the bench receiver: every byte value, all three variants.
        fork
            stream(0);
            stream(1);
            stream(2);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
